// File: rtl/etc_pkg.sv
// rtl/etc_pkg.sv - shared constants, state encoding and address helper for the ETC2 pixel writer
// Contents:
//   BLOCK_DIM / TEXELS_PER_BLOCK  ETC2 block geometry (4x4 texels)
//   IMG_W_DEFAULT / IMG_H_DEFAULT default framebuffer dimensions
//   writer_state_t                pixel writer FSM states
//   texel_linear()                block coords + texel index -> linear framebuffer index
package etc_pkg;

    localparam int BLOCK_DIM        = 4;
    localparam int TEXELS_PER_BLOCK = 16;
    localparam int IMG_W_DEFAULT    = 128;
    localparam int IMG_H_DEFAULT    = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DEC,
        ST_WRITE,
        ST_ACK,
        ST_REARM,
        ST_DONE
    } writer_state_t;

    // ETC2 orders texels column-major inside a block: idx[3:2] is the column,
    // idx[1:0] the row.
    function automatic logic [31:0] texel_linear(
        input logic [7:0]  bx,
        input logic [7:0]  by,
        input logic [3:0]  idx,
        input logic [31:0] img_w
    );
        logic [31:0] x;
        logic [31:0] y;
        x = 32'(bx) * 32'(BLOCK_DIM) + 32'(idx[3:2]);
        y = 32'(by) * 32'(BLOCK_DIM) + 32'(idx[1:0]);
        return y * img_w + x;
    endfunction

endpackage

// File: rtl/etc_fb_addr_gen.sv
// rtl/etc_fb_addr_gen.sv - latches block coordinates and texel index, produces framebuffer address and range error
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load               capture block_x/block_y/pix_idx this cycle
//   block_x, block_y   block column / row
//   pix_idx            texel index inside the block (0..15)
//   addr               framebuffer address, truncated to ADDR_W
//   range_err          block coordinates outside the image
module etc_fb_addr_gen
    import etc_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [7:0]        block_x,
    input  logic [7:0]        block_y,
    input  logic [3:0]        pix_idx,
    output logic [ADDR_W-1:0] addr,
    output logic              range_err
);

    logic [7:0] bx_q;
    logic [7:0] by_q;
    logic [3:0] idx_q;
    logic [7:0] bx;
    logic [7:0] by;
    logic [3:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            bx_q  <= '0;
            by_q  <= '0;
            idx_q <= '0;
        end else if (load) begin
            bx_q  <= block_x;
            by_q  <= block_y;
            idx_q <= pix_idx;
        end
    end

    // While loading, the live inputs are forwarded so a zero-latency decoder
    // can write in the cycle right after the accept.
    always_comb begin
        bx        = load ? block_x : bx_q;
        by        = load ? block_y : by_q;
        idx       = load ? pix_idx : idx_q;
        range_err = (32'(bx) >= 32'(IMG_W / BLOCK_DIM)) ||
                    (32'(by) >= 32'(IMG_H / BLOCK_DIM));
        addr      = ADDR_W'(texel_linear(bx, by, idx, 32'(IMG_W)));
    end

endmodule

// File: rtl/etc_pixel_writer.sv
// rtl/etc_pixel_writer.sv - writes ETC2-decoded texels to the framebuffer and acknowledges the fetcher
// Ports:
//   sclk, rsrt                    clock, synchronous active-high reset
//   valid                         fetcher offers blockX_in/blockY_in/pixIdx_in
//   blockX_in, blockY_in          block column / row
//   pixIdx_in                     texel index (16 = fetcher wrap transient, ignored)
//   image_finished                fetcher has consumed all blocks
//   pixel_in                      decoded texel from the ETC2 decoder
//   write_finish                  one-cycle ack to the fetcher
//   fb_we, fb_addr, fb_data       framebuffer write port
//   pix_count                     texels written since reset
//   frame_done                    sticky, whole frame written
//   err_flag                      sticky, bad coordinates or early image_finished
module etc_pixel_writer
    import etc_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEFAULT,
    parameter int IMG_H   = IMG_H_DEFAULT,
    parameter int PIX_W   = 24,
    parameter int DEC_LAT = 2,
    parameter int ADDR_W  = 14
) (
    input  logic              sclk,
    input  logic              rsrt,
    input  logic              valid,
    input  logic [7:0]        blockX_in,
    input  logic [7:0]        blockY_in,
    input  logic [4:0]        pixIdx_in,
    input  logic              image_finished,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic              write_finish,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    output logic [ADDR_W:0]   pix_count,
    output logic              frame_done,
    output logic              err_flag
);

    localparam logic [ADDR_W:0] FRAME_TEXELS = (ADDR_W+1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W:0] COUNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [2:0]      DEC_CYCLES   = 3'(DEC_LAT);
    localparam bit              NO_DEC_WAIT  = (DEC_LAT == 0);

    writer_state_t     state;
    logic [2:0]        dcnt;
    logic              accept;
    logic              go_write;
    logic              gen_err;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W:0]   next_count;

    assign accept = (state == ST_IDLE) && valid && !frame_done &&
                    (32'(pixIdx_in) < 32'(TEXELS_PER_BLOCK));

    // WAIT_DEC lasts DEC_LAT cycles; the texel is sampled on the edge that
    // enters WRITE, which is the end of the decoder's first valid cycle.
    assign go_write = (accept && NO_DEC_WAIT) ||
                      ((state == ST_WAIT_DEC) && (dcnt <= 3'd1));

    assign next_count = pix_count + COUNT_ONE;

    etc_fb_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (sclk),
        .rst       (rsrt),
        .load      (accept),
        .block_x   (blockX_in),
        .block_y   (blockY_in),
        .pix_idx   (pixIdx_in[3:0]),
        .addr      (gen_addr),
        .range_err (gen_err)
    );

    always_ff @(posedge sclk) begin
        if (rsrt) begin
            state        <= ST_IDLE;
            dcnt         <= '0;
            write_finish <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
            pix_count    <= '0;
            frame_done   <= 1'b0;
            err_flag     <= 1'b0;
        end else begin
            write_finish <= 1'b0;
            fb_we        <= 1'b0;

            if ((state == ST_IDLE) && image_finished && !frame_done) begin
                err_flag <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (gen_err) begin
                            err_flag <= 1'b1;
                        end
                        dcnt  <= DEC_CYCLES;
                        state <= NO_DEC_WAIT ? ST_WRITE : ST_WAIT_DEC;
                    end
                end
                ST_WAIT_DEC: begin
                    dcnt <= dcnt - 3'd1;
                    if (go_write) begin
                        state <= ST_WRITE;
                    end
                end
                // Out-of-range texels keep the WRITE slot (with fb_we low) so the
                // fetcher sees the same ack latency either way.
                ST_WRITE: begin
                    write_finish <= 1'b1;
                    state        <= ST_ACK;
                    if (!gen_err) begin
                        pix_count <= next_count;
                        if (next_count == FRAME_TEXELS) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    state <= frame_done ? ST_DONE : ST_REARM;
                end
                // The fetcher may still show the acknowledged texel; wait for
                // valid to drop before listening again.
                ST_REARM: begin
                    if (!valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (go_write) begin
                fb_we <= !gen_err;
                if (!gen_err) begin
                    fb_addr <= gen_addr;
                    fb_data <= pixel_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_etc_pixel_writer.sv
// tb/tb_etc_pixel_writer.sv - scoreboard bench for etc_pixel_writer with a fetcher/decoder model
module tb_etc_pixel_writer;

    localparam int IMG_W   = 128;
    localparam int IMG_H   = 64;
    localparam int PIX_W   = 24;
    localparam int DEC_LAT = 2;
    localparam int ADDR_W  = 13;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int BW      = IMG_W / 4;
    localparam int BH      = IMG_H / 4;

    logic              sclk = 1'b0;
    logic              rsrt = 1'b1;
    logic              valid = 1'b0;
    logic [7:0]        blockX_in = '0;
    logic [7:0]        blockY_in = '0;
    logic [4:0]        pixIdx_in = '0;
    logic              image_finished = 1'b0;
    logic [PIX_W-1:0]  pixel_in = '0;
    logic              write_finish;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_data;
    logic [ADDR_W:0]   pix_count;
    logic              frame_done;
    logic              err_flag;

    etc_pixel_writer #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PIX_W   (PIX_W),
        .DEC_LAT (DEC_LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .sclk           (sclk),
        .rsrt           (rsrt),
        .valid          (valid),
        .blockX_in      (blockX_in),
        .blockY_in      (blockY_in),
        .pixIdx_in      (pixIdx_in),
        .image_finished (image_finished),
        .pixel_in       (pixel_in),
        .write_finish   (write_finish),
        .fb_we          (fb_we),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .pix_count      (pix_count),
        .frame_done     (frame_done),
        .err_flag       (err_flag)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  we_cnt = 0;
    int  wf_cnt = 0;
    int  we_cyc = 0;
    int  uniq = 0;
    int  exp_count = 0;
    int  last_addr = 0;
    bit  seen [NPIX];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference address: column-major texels inside 4x4 blocks, row-major image.
    function automatic int model_addr(input int bx, input int by, input int p);
        int x;
        int y;
        x = bx * 4 + p / 4;
        y = by * 4 + p % 4;
        return y * IMG_W + x;
    endfunction

    // Monitor: every framebuffer write is matched against the scoreboard.
    always @(negedge sclk) begin
        wr_t e;
        if (fb_we === 1'b1) begin
            we_cnt++;
            we_cyc = cyc;
            check("sb_nonempty_on_write", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("fb_addr", fb_addr, e.addr);
                check("fb_data", fb_data, e.data);
            end
            if (!seen[fb_addr]) begin
                seen[fb_addr] = 1'b1;
                uniq++;
            end
        end
        if (write_finish === 1'b1) wf_cnt++;
    end

    task automatic do_reset();
        rsrt = 1'b1;
        valid = 1'b0;
        image_finished = 1'b0;
        repeat (2) begin
            @(posedge sclk);
            #1;
        end
        rsrt = 1'b0;
        exp_q.delete();
        exp_count = 0;
        uniq = 0;
        foreach (seen[i]) seen[i] = 1'b0;
    endtask

    // Fetcher + decoder model for one texel. Called with the DUT idle, just after a posedge.
    task automatic send(input int bx, input int by, input int p, input logic [PIX_W-1:0] d, input int hold);
        int  t0;
        int  we0;
        int  wf0;
        bit  ok;
        bit  good;
        wr_t e;
        good = (bx < BW) && (by < BH);
        we0 = we_cnt;
        wf0 = wf_cnt;
        blockX_in = 8'(bx);
        blockY_in = 8'(by);
        pixIdx_in = 5'(p);
        pixel_in  = d;
        valid     = 1'b1;
        t0 = cyc;
        if (good) begin
            e.addr = ADDR_W'(model_addr(bx, by, p));
            e.data = d;
            exp_q.push_back(e);
            exp_count++;
            last_addr = model_addr(bx, by, p);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge sclk);
            if (write_finish === 1'b1) ok = 1'b1;
        end
        check("ack_seen", ok, 1);
        if (ok) begin
            check("ack_latency", cyc - t0, DEC_LAT + 2);
            if (good) check("we_latency", we_cyc - t0, DEC_LAT + 1);
        end
        repeat (hold + 1) begin
            @(posedge sclk);
            #1;
        end
        valid = 1'b0;
        @(posedge sclk);
        #1;
        check("we_pulses", we_cnt - we0, good);
        check("ack_pulses", wf_cnt - wf0, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int wf0;
        logic [PIX_W-1:0] d;

        do_reset();
        check("rst_fb_we", fb_we, 0);
        check("rst_write_finish", write_finish, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_flag", err_flag, 0);

        d = PIX_W'($urandom());
        send(0, 0, 5, d, 0);
        check("t1_fb_addr_hold", fb_addr, 129);
        check("t1_fb_data_hold", fb_data, d);

        send(BW - 1, BH - 1, 15, 24'hABCDEF, 0);
        check("t2_fb_addr_last", fb_addr, NPIX - 1);
        check("t2_fb_data", fb_data, 24'hABCDEF);

        for (int n = 0; n < 30; n++) begin
            send(int'($urandom_range(0, BW - 1)), int'($urandom_range(0, BH - 1)),
                 int'($urandom_range(0, 15)), PIX_W'($urandom()), int'($urandom_range(0, 2)));
        end

        send(3, 2, 9, PIX_W'($urandom()), 5);

        we0 = we_cnt;
        wf0 = wf_cnt;
        blockX_in = 8'd4;
        blockY_in = 8'd4;
        pixIdx_in = 5'd16;
        valid = 1'b1;
        repeat (8) begin
            @(posedge sclk);
            #1;
        end
        valid = 1'b0;
        @(posedge sclk);
        #1;
        check("t4_no_write", we_cnt - we0, 0);
        check("t4_no_ack", wf_cnt - wf0, 0);
        check("t4_err_flag", err_flag, 0);
        check("pix_count_model", pix_count, exp_count);

        send(BW, 0, 3, PIX_W'($urandom()), 0);
        send(0, BH, 0, PIX_W'($urandom()), 0);
        check("oor_err_flag", err_flag, 1);
        check("oor_pix_count", pix_count, exp_count);
        check("oor_fb_addr_hold", fb_addr, last_addr);

        do_reset();
        check("rst2_err_flag", err_flag, 0);
        check("rst2_pix_count", pix_count, 0);

        we0 = we_cnt;
        wf0 = wf_cnt;
        blockX_in = 8'd1;
        blockY_in = 8'd1;
        pixIdx_in = 5'd0;
        valid = 1'b1;
        @(posedge sclk);
        #1;
        rsrt = 1'b1;
        valid = 1'b0;
        @(posedge sclk);
        #1;
        rsrt = 1'b0;
        repeat (6) begin
            @(posedge sclk);
            #1;
        end
        check("t6_abort_no_write", we_cnt - we0, 0);
        check("t6_abort_no_ack", wf_cnt - wf0, 0);
        check("t6_abort_pix_count", pix_count, 0);

        image_finished = 1'b1;
        @(posedge sclk);
        #1;
        image_finished = 1'b0;
        check("t6_early_finish_err", err_flag, 1);

        do_reset();
        for (int by = 0; by < BH; by++) begin
            for (int bx = 0; bx < BW; bx++) begin
                for (int p = 0; p < 16; p++) begin
                    send(bx, by, p, PIX_W'($urandom()), ($urandom_range(0, 15) == 0) ? 1 : 0);
                end
                pixIdx_in = 5'd16;
                valid = 1'b1;
                @(posedge sclk);
                #1;
                valid = 1'b0;
            end
        end
        check("t5_unique_addrs", uniq, NPIX);
        check("t5_frame_done", frame_done, 1);
        check("t5_pix_count", pix_count, NPIX);
        check("t5_err_flag", err_flag, 0);
        check("t5_sb_drained", exp_q.size(), 0);

        we0 = we_cnt;
        wf0 = wf_cnt;
        blockX_in = 8'd0;
        blockY_in = 8'd0;
        pixIdx_in = 5'd0;
        valid = 1'b1;
        repeat (10) begin
            @(posedge sclk);
            #1;
        end
        valid = 1'b0;
        image_finished = 1'b1;
        repeat (3) begin
            @(posedge sclk);
            #1;
        end
        image_finished = 1'b0;
        check("done_no_write", we_cnt - we0, 0);
        check("done_no_ack", wf_cnt - wf0, 0);
        check("done_err_flag", err_flag, 0);
        check("done_frame_done", frame_done, 1);
        check("done_pix_count", pix_count, NPIX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
